// File: rtl/filt_fir_mc_pkg.sv
// Shared types and elaboration-time width helpers for the multi-channel FIR.
package filt_fir_mc_pkg;

  typedef enum logic [1:0] {StIdle, StMac, StOut} fir_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Wide enough that a full-scale dot product can never wrap.
  function automatic int unsigned acc_width(input int unsigned inp_w,
                                            input int unsigned coeff_w,
                                            input int unsigned len,
                                            input int unsigned symm);
    return inp_w + coeff_w + $clog2(len) + symm;
  endfunction

  function automatic int unsigned mac_count(input int unsigned len, input int unsigned symm);
    return (symm != 0) ? (len + 1) / 2 : len;
  endfunction

endpackage

// File: rtl/filt_fir_mc_mac.sv
// Combinational MAC step: pre-add, multiply, accumulate, then round and saturate the sum.
module filt_fir_mc_mac #(
  parameter int unsigned InpW   = 16,
  parameter int unsigned CoeffW = 16,
  parameter int unsigned AccW   = 36,
  parameter int unsigned OupW   = 16,
  parameter int unsigned Shift  = 15
) (
  input  logic signed [InpW-1:0]   x_a_i,
  input  logic signed [InpW-1:0]   x_b_i,
  input  logic signed [CoeffW-1:0] coeff_i,
  input  logic signed [AccW-1:0]   acc_i,
  output logic signed [AccW-1:0]   acc_o,
  output logic signed [OupW-1:0]   res_o
);

  localparam logic signed [AccW:0] RndAdd =
      (Shift > 0) ? ((AccW + 1)'(1) << (Shift - 1)) : '0;
  localparam logic signed [AccW:0] OupMax = {{(AccW - OupW + 2){1'b0}}, {(OupW - 1){1'b1}}};
  localparam logic signed [AccW:0] OupMin = {{(AccW - OupW + 2){1'b1}}, {(OupW - 1){1'b0}}};

  logic signed [InpW:0]        pre_add;
  logic signed [InpW+CoeffW:0] prod;
  logic signed [AccW:0]        rnd;
  logic signed [AccW:0]        shf;

  always_comb begin
    pre_add = {x_a_i[InpW-1], x_a_i} + {x_b_i[InpW-1], x_b_i};
    prod    = pre_add * coeff_i;
    acc_o   = acc_i + AccW'(prod);
    // One extra bit so the rounding offset cannot wrap a near-full-scale sum.
    rnd     = {acc_o[AccW-1], acc_o} + RndAdd;
    shf     = rnd >>> Shift;
    if (shf > OupMax) begin
      res_o = OupMax[OupW-1:0];
    end else if (shf < OupMin) begin
      res_o = OupMin[OupW-1:0];
    end else begin
      res_o = shf[OupW-1:0];
    end
  end

endmodule

// File: rtl/filt_fir_mc.sv
// Time-multiplexed multi-channel FIR: one multiply per cycle, optional symmetric pre-add.
module filt_fir_mc
  import filt_fir_mc_pkg::*;
#(
  parameter int unsigned gp_inp_width    = 16,
  parameter int unsigned gp_coeff_width  = 16,
  parameter int unsigned gp_coeff_length = 16,
  parameter int unsigned gp_nr_ch        = 4,
  parameter int unsigned gp_symm         = 0,
  parameter int unsigned gp_oup_shift    = 15,
  parameter int unsigned gp_oup_width    = 16
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_ena,
  input  logic                                         i_valid,
  input  logic [clog2_min1(gp_nr_ch)-1:0]              i_ch,
  input  logic signed [gp_inp_width-1:0]               i_data,
  output logic                                         o_ready,
  input  logic                                         i_coeff_we,
  input  logic [clog2_min1(gp_coeff_length)-1:0]       i_coeff_addr,
  input  logic signed [gp_coeff_width-1:0]             i_coeff_data,
  output logic                                         o_valid,
  output logic [clog2_min1(gp_nr_ch)-1:0]              o_ch,
  output logic signed [gp_oup_width-1:0]               o_data
);

  localparam int unsigned ChW   = clog2_min1(gp_nr_ch);
  localparam int unsigned AddrW = clog2_min1(gp_coeff_length);
  localparam int unsigned AccW  = acc_width(gp_inp_width, gp_coeff_width, gp_coeff_length,
                                            gp_symm);
  localparam int unsigned NrMac = mac_count(gp_coeff_length, gp_symm);

  fir_state_e                  state_q, state_d;
  logic [AddrW-1:0]            cnt_q, mirror;
  logic [ChW-1:0]              ch_q, o_ch_q;
  logic signed [AccW-1:0]      acc_q, acc_d;
  logic signed [gp_oup_width-1:0] res, o_data_q;
  logic signed [gp_inp_width-1:0] dline_q [gp_nr_ch][gp_coeff_length];
  logic signed [gp_coeff_width-1:0] coeff_q [gp_coeff_length];
  logic signed [gp_inp_width-1:0] tap_a, tap_b;
  logic signed [gp_coeff_width-1:0] tap_c;
  logic                        accept, coeff_wr, last_mac;

  assign accept   = o_ready & i_valid & (32'(i_ch) < gp_nr_ch);
  assign coeff_wr = o_ready & i_coeff_we;
  assign last_mac = (cnt_q == AddrW'(NrMac - 1));
  assign mirror   = AddrW'(gp_coeff_length - 1) - cnt_q;
  assign o_ch     = o_ch_q;
  assign o_data   = o_data_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else if (i_ena) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StMac;
      StMac:   if (last_mac) state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_ready = i_ena & (state_q == StIdle);
    o_valid = (state_q == StOut);
  end

  // Tap k pairs with its mirror L-1-k; the odd-length centre tap has no partner.
  always_comb begin
    tap_a = '0;
    tap_b = '0;
    tap_c = '0;
    for (int unsigned k = 0; k < gp_coeff_length; k++) begin
      if (32'(cnt_q) == k) tap_c = coeff_q[k];
      for (int unsigned c = 0; c < gp_nr_ch; c++) begin
        if (32'(ch_q) == c) begin
          if (32'(cnt_q) == k) tap_a = dline_q[c][k];
          if ((gp_symm != 0) && (32'(mirror) == k) && (mirror != cnt_q)) tap_b = dline_q[c][k];
        end
      end
    end
  end

  filt_fir_mc_mac #(
    .InpW   (gp_inp_width),
    .CoeffW (gp_coeff_width),
    .AccW   (AccW),
    .OupW   (gp_oup_width),
    .Shift  (gp_oup_shift)
  ) u_mac (
    .x_a_i   (tap_a),
    .x_b_i   (tap_b),
    .coeff_i (tap_c),
    .acc_i   (acc_q),
    .acc_o   (acc_d),
    .res_o   (res)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      ch_q     <= '0;
      o_ch_q   <= '0;
      o_data_q <= '0;
      for (int unsigned c = 0; c < gp_nr_ch; c++) begin
        for (int unsigned k = 0; k < gp_coeff_length; k++) dline_q[c][k] <= '0;
      end
      for (int unsigned k = 0; k < gp_coeff_length; k++) coeff_q[k] <= '0;
    end else if (i_ena) begin
      if (accept) begin
        for (int unsigned c = 0; c < gp_nr_ch; c++) begin
          if (32'(i_ch) == c) begin
            dline_q[c][0] <= i_data;
            for (int unsigned k = 1; k < gp_coeff_length; k++) dline_q[c][k] <= dline_q[c][k-1];
          end
        end
        acc_q <= '0;
        cnt_q <= '0;
        ch_q  <= i_ch;
      end else if (state_q == StMac) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + AddrW'(1);
        if (last_mac) begin
          o_data_q <= res;
          o_ch_q   <= ch_q;
        end
      end
      // Out-of-range addresses match no entry and are dropped.
      if (coeff_wr) begin
        for (int unsigned k = 0; k < gp_coeff_length; k++) begin
          if (32'(i_coeff_addr) == k) coeff_q[k] <= i_coeff_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_filt_fir_mc.sv
// Directed bench: three filt_fir_mc configurations driven from one shared stimulus bus.
module tb_filt_fir_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ena, valid, ch, cwe;
  logic signed [15:0] data, cdata;
  logic [2:0] caddr;
  int sel;
  int n_checks = 0;
  int n_fail = 0;

  logic rdy_a, vld_a, och_a, rdy_s, vld_s, och_s, rdy_q, vld_q, och_q;
  logic signed [15:0] dat_a, dat_s, dat_q;

  filt_fir_mc #(.gp_coeff_length(4), .gp_nr_ch(2), .gp_oup_shift(0)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_valid(valid && sel == 0), .i_ch(ch),
    .i_data(data), .o_ready(rdy_a), .i_coeff_we(cwe && sel == 0), .i_coeff_addr(caddr[1:0]),
    .i_coeff_data(cdata), .o_valid(vld_a), .o_ch(och_a), .o_data(dat_a));

  filt_fir_mc #(.gp_coeff_length(5), .gp_nr_ch(1), .gp_symm(1), .gp_oup_shift(0)) u_dut_s (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_valid(valid && sel == 1), .i_ch(ch),
    .i_data(data), .o_ready(rdy_s), .i_coeff_we(cwe && sel == 1), .i_coeff_addr(caddr),
    .i_coeff_data(cdata), .o_valid(vld_s), .o_ch(och_s), .o_data(dat_s));

  filt_fir_mc #(.gp_coeff_length(4), .gp_nr_ch(1), .gp_oup_shift(15)) u_dut_q (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_valid(valid && sel == 2), .i_ch(ch),
    .i_data(data), .o_ready(rdy_q), .i_coeff_we(cwe && sel == 2), .i_coeff_addr(caddr[1:0]),
    .i_coeff_data(cdata), .o_valid(vld_q), .o_ch(och_q), .o_data(dat_q));

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic cur_vld();
    case (sel)
      0: return vld_a;
      1: return vld_s;
      default: return vld_q;
    endcase
  endfunction

  function automatic logic cur_rdy();
    case (sel)
      0: return rdy_a;
      1: return rdy_s;
      default: return rdy_q;
    endcase
  endfunction

  function automatic logic cur_ch();
    case (sel)
      0: return och_a;
      1: return och_s;
      default: return och_q;
    endcase
  endfunction

  function automatic longint cur_dat();
    case (sel)
      0: return longint'(dat_a);
      1: return longint'(dat_s);
      default: return longint'(dat_q);
    endcase
  endfunction

  task automatic write_coeff(input int s, input int a, input int v);
    @(negedge clk);
    sel = s; cwe = 1'b1; caddr = 3'(a); cdata = 16'(v);
    @(negedge clk);
    cwe = 1'b0;
  endtask

  // lat counts negedges from the accept edge until o_valid is seen (N+1 when unstalled).
  task automatic send(input int s, input logic c, input int d, input bit stall,
                      input int exp_lat, input longint exp_dat, input string tag);
    int lat;
    @(negedge clk);
    sel = s; ch = c; data = 16'(d); valid = 1'b1;
    check({tag, "_rdy"}, longint'(cur_rdy()), 1);
    @(negedge clk);
    valid = 1'b0;
    lat = 1;
    while (!cur_vld() && lat < 40) begin
      if (stall) ena = !(lat >= 2 && lat < 5);
      @(negedge clk);
      lat++;
    end
    ena = 1'b1;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_dat"}, cur_dat(), exp_dat);
    check({tag, "_ch"}, longint'(cur_ch()), longint'(c));
    @(negedge clk);
    check({tag, "_pulse"}, longint'(cur_vld()), 0);
  endtask

  int imp_exp[4] = '{1, 2, 3, 4};
  int iso_exp1[4] = '{10, 30, 60, 100};
  int sym_exp[5] = '{1, 2, 3, 2, 1};
  int sat_exp[8] = '{32766, 32767, 32767, 32767, 32767, -2, -32768, -32768};
  logic seen;

  initial begin
    rst = 1'b1; ena = 1'b1; valid = 1'b0; ch = 1'b0; cwe = 1'b0;
    data = '0; cdata = '0; caddr = '0; sel = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_rdy_a", longint'(rdy_a), 1);
    check("rst_vld_a", longint'(vld_a), 0);
    check("rst_dat_a", longint'(dat_a), 0);
    check("rst_och_a", longint'(och_a), 0);
    check("rst_vld_s", longint'(vld_s), 0);
    check("rst_dat_q", longint'(dat_q), 0);

    for (int i = 0; i < 4; i++) write_coeff(0, i, i + 1);
    for (int i = 0; i < 4; i++)
      send(0, 1'b0, (i == 0) ? 1 : 0, 1'b0, 5, imp_exp[i], $sformatf("imp%0d", i));

    for (int i = 0; i < 4; i++) begin
      send(0, 1'b0, (i == 0) ? 1 : 0, 1'b0, 5, imp_exp[i], $sformatf("iso0_%0d", i));
      send(0, 1'b1, 10, 1'b0, 5, iso_exp1[i], $sformatf("iso1_%0d", i));
    end

    send(0, 1'b0, 5, 1'b1, 8, 5, "stall");
    send(0, 1'b0, 0, 1'b0, 5, 10, "post_stall");

    for (int i = 0; i < 3; i++) write_coeff(1, i, i + 1);
    write_coeff(1, 5, 99);
    for (int i = 0; i < 5; i++)
      send(1, 1'b0, (i == 0) ? 1 : 0, 1'b0, 4, sym_exp[i], $sformatf("sym%0d", i));

    @(negedge clk);
    sel = 1; ch = 1'b1; data = 16'sd7; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; ch = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      if (vld_s) seen = 1'b1;
      @(negedge clk);
    end
    check("drop_novld", longint'(seen), 0);
    check("drop_rdy", longint'(rdy_s), 1);
    send(1, 1'b0, 2, 1'b0, 4, 2, "drop_next");

    for (int i = 0; i < 4; i++) write_coeff(2, i, 32767);
    for (int i = 0; i < 8; i++)
      send(2, 1'b0, (i < 4) ? 32767 : -32768, 1'b0, 5, sat_exp[i], $sformatf("sat%0d", i));

    @(negedge clk);
    sel = 0; ch = 1'b0; data = 16'sd3; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rdy", longint'(rdy_a), 1);
    check("midrst_dat", longint'(dat_a), 0);
    seen = 1'b0;
    repeat (8) begin
      if (vld_a) seen = 1'b1;
      @(negedge clk);
    end
    check("midrst_novld", longint'(seen), 0);
    send(0, 1'b0, 1, 1'b0, 5, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/filt_fir_mc.md
FILT_FIR_MC -- requirements
Module: filt_fir_mc

Interface
REQ-001 SHALL have parameter gp_inp_width, default 16, meaning signed input sample width.
REQ-002 SHALL have parameter gp_coeff_width, default 16, meaning signed coefficient width.
REQ-003 SHALL have parameter gp_coeff_length, default 16, meaning tap count L (L>=2).
REQ-004 SHALL have parameter gp_nr_ch, default 4, meaning independent channel count C (C>=1).
REQ-005 SHALL have parameter gp_symm, default 0, meaning 1 = symmetric coefficients with pre-add.
REQ-006 SHALL have parameter gp_oup_shift, default 15, meaning arithmetic right shift applied to accumulator.
REQ-007 SHALL have parameter gp_oup_width, default 16, meaning signed output width.
REQ-008 SHALL have port i_clk, input, 1, meaning sole clock; all logic on rising edge.
REQ-009 SHALL have port i_rst, input, 1, meaning reset; synchronous, active-high.
REQ-010 SHALL have port i_ena, input, 1, meaning global clock enable; low holds all state.
REQ-011 SHALL have port i_valid, input, 1, meaning input sample offered.
REQ-012 SHALL have port i_ch, input, clog2(C) (min 1), meaning channel of offered sample.
REQ-013 SHALL have port i_data, input, gp_inp_width, meaning signed input sample.
REQ-014 SHALL have port o_ready, output, 1, meaning sample and coefficient writes accepted this cycle.
REQ-015 SHALL have port i_coeff_we, input, 1, meaning coefficient write strobe.
REQ-016 SHALL have port i_coeff_addr, input, clog2(L), meaning coefficient index.
REQ-017 SHALL have port i_coeff_data, input, gp_coeff_width, meaning signed coefficient value.
REQ-018 SHALL have port o_valid, output, 1, meaning one-cycle result strobe.
REQ-019 SHALL have port o_ch, output, clog2(C), meaning channel of result.
REQ-020 SHALL have port o_data, output, gp_oup_width, meaning signed filtered result.

Function
REQ-021 SHALL implement states IDLE, MAC, OUT; o_ready = 1 only in IDLE with i_ena high.
REQ-022 SHALL accept a sample on an edge with i_valid & o_ready & i_ch<C: shift i_data into channel i_ch delay line (length L), clear accumulator, latch channel, go IDLE->MAC.
REQ-023 SHALL drop samples with i_ch>=C silently, remaining in IDLE with no output.
REQ-024 SHALL run N MAC cycles, N = L if gp_symm=0, N = ceil(L/2) if gp_symm=1, one multiply per cycle, then MAC->OUT.
REQ-025 SHALL in symmetric mode pre-add x[k]+x[L-1-k] using coefficient k; for odd L the middle tap uses x[(L-1)/2] alone.
REQ-026 SHALL size accumulator W = gp_inp_width+gp_coeff_width+clog2(L)+gp_symm bits, no internal overflow.
REQ-027 SHALL form o_data = saturate(round-half-up(acc >> gp_oup_shift)) to gp_oup_width, i.e. add 2^(shift-1) before shift when shift>0.
REQ-028 SHALL assert o_valid, o_ch, o_data for exactly one enabled cycle in OUT, then return to IDLE; latency accept-edge to o_valid = N+1 enabled cycles.
REQ-029 SHALL hold o_data/o_ch between strobes; o_valid 0 outside OUT.
REQ-030 SHALL write coefficient on i_coeff_we & o_ready; addr>=L or write outside IDLE ignored; same-edge sample accept and coefficient write both take effect, new coefficient used by that sample.
REQ-031 SHALL freeze state, counters, delay lines and outputs (o_valid held) while i_ena low.
REQ-032 SHALL keep channels isolated: a sample on one channel never alters another channel's delay line.

Reset
REQ-033 SHALL, on i_rst high at an edge (regardless of i_ena), enter IDLE, clear all delay lines, coefficients, accumulator, o_valid, o_ch, o_data to 0.
REQ-034 SHALL abort an in-progress MAC on reset with no o_valid produced.

Structure
REQ-035 SHALL place state enum, width functions (clog2, accumulator width) in package filt_fir_mc_pkg.
REQ-036 SHALL instantiate one sub-module filt_fir_mc_mac (pre-add, multiply, accumulate, round, saturate).

Verification
REQ-037 Impulse: L=4, C=2, coeffs 1,2,3,4, shift 0; ch0 inputs 1,0,0,0 -> ch0 o_data 1,2,3,4, each N+1=5 cycles after accept.
REQ-038 Isolation: interleave ch0 impulse 1 and ch1 constant 10 -> ch0 1,2,3,4; ch1 10,30,60,100.
REQ-039 Saturation: 16-bit, coeffs all 32767, shift 15, inputs 32767 -> o_data clamps 32767; inputs -32768 -> -32768.
REQ-040 Symmetric: gp_symm=1, L=5, coeffs 1,2,3 written addr 0..2, impulse 1 -> outputs 1,2,3,2,1, latency 4 cycles.
REQ-041 Reset mid-MAC: i_rst one cycle during MAC -> no o_valid, o_ready next cycle, next impulse gives all-zero coeff output 0.
REQ-042 Enable stall: drop i_ena 3 cycles during MAC -> result identical, latency extended by exactly 3 cycles.
